multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter ALU_CTRL_W, default 4, meaning the alu_control width (minimum 4).
REQ-002 The block SHALL have parameter HAS_ADDI, default 1, meaning ADDI (op 001000) is decoded; when 0, ADDI is illegal.
REQ-003 The block SHALL have parameter HAS_BNE, default 1, meaning BNE (op 000101) is decoded; when 0, BNE is illegal.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  the reset, asynchronous and active-high.
REQ-006 The block SHALL have ports op  input  6  opcode, and funct  input  6  R-type function field; both sampled from the instruction register.
REQ-007 The block SHALL have port zero  input  1  ALU zero flag.
REQ-008 The block SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-009 The block SHALL have ports mem_req  output  1  and mem_write  output  1; mem_req is the memory access request and mem_write is the write strobe.
REQ-010 The block SHALL have ports iord, ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write  output  1 each, with the standard multicycle datapath meanings.
REQ-011 The block SHALL have ports alu_src_b  output  2  and pc_src  output  2  datapath mux selects.
REQ-012 The block SHALL have port alu_control  output  ALU_CTRL_W  ALU operation, zero-extended from the 4-bit code.
REQ-013 The block SHALL have ports state  output  4  current state, for debug, and illegal_op  output  1  one-cycle flag.

Function
REQ-014 The FSM SHALL have these states and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, JUMP=10.
REQ-015 FETCH SHALL assert mem_req=1, iord=0, alu_src_a=0, alu_src_b=01 and alu_control=ADD, and SHALL hold until mem_ready; in the mem_ready cycle it SHALL assert ir_write=1 and pc_en=1 with pc_src=00, then go to DECODE.
REQ-016 DECODE SHALL assert alu_src_a=0 and alu_src_b=11 with ADD, and SHALL branch on op: LW/SW to MEMADR, R-type to RTEXEC, BEQ or BNE to BRANCH, ADDI to ADDIEX, J to JUMP.
REQ-017 Any other op in DECODE SHALL go to FETCH and pulse illegal_op for that cycle; this also applies to BNE when HAS_BNE=0 and to ADDI when HAS_ADDI=0.
REQ-018 MEMADR SHALL assert alu_src_a=1 and alu_src_b=10 with ADD, then go to MEMRD when op is LW or to MEMWR when op is SW.
REQ-019 MEMRD SHALL assert mem_req=1 and iord=1 and SHALL wait for mem_ready, then go to MEMWB.
REQ-020 MEMWB SHALL assert reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-021 MEMWR SHALL assert mem_req=1, iord=1 and mem_write=1, holding these while waiting for mem_ready, then go to FETCH.
REQ-022 RTEXEC SHALL assert alu_src_a=1 and alu_src_b=00, with alu_control decoded from funct: 100000 to ADD 0010, 100010 to SUB 0110, 100100 to AND 0000, 100101 to OR 0001, 100111 to NOR 1100, 101010 to SLT 0111.
REQ-023 An unknown funct in RTEXEC SHALL go to FETCH with no writeback and pulse illegal_op.
REQ-024 ALUWB SHALL assert reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-025 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, SUB and pc_src=01, set pc_en = zero for BEQ or ~zero for BNE, then go to FETCH.
REQ-026 ADDIEX SHALL assert alu_src_a=1 and alu_src_b=10 with ADD, then go to ALUWB with reg_dst forced to 0 for that writeback.
REQ-027 JUMP SHALL assert pc_src=10 and pc_en=1, then go to FETCH.
REQ-028 All outputs SHALL be combinational from the state and inputs (Moore, plus the mem_ready, zero and op terms listed), and any output not named for a state SHALL be 0.
REQ-029 Each instruction SHALL take this many cycles with mem_ready tied high: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3.
REQ-030 Each memory wait cycle SHALL add exactly one cycle of latency.
REQ-031 mem_write and reg_write SHALL never both be high, and ir_write SHALL be asserted only in FETCH.

Reset
REQ-032 reset=1 SHALL force state to FETCH immediately, without waiting for a clk edge, including mid-instruction and mid-wait.
REQ-033 During reset, all write strobes (ir_write, pc_en, reg_write, mem_write) SHALL be 0.
REQ-034 On the first clk edge after reset is released, the FSM SHALL evaluate FETCH normally, so that FETCH outputs apply immediately.

Verification
REQ-035 Reset, then R-type ADD (op 000000, funct 100000) with mem_ready=1: states SHALL be 0,1,6,7,0, alu_control=0010 in state 6, reg_write=1 and reg_dst=1 in state 7.
REQ-036 LW with mem_ready low for 2 cycles in MEMRD: state 3 SHALL hold for 3 cycles, then state 4 SHALL show mem_to_reg=1 and reg_write=1; total 7 cycles.
REQ-037 BEQ with zero=1 SHALL give pc_en=1 and pc_src=01 in state 8; BNE with zero=1 SHALL give pc_en=0.
REQ-038 J (op 000010) SHALL give pc_en=1 and pc_src=10 in state 10; op 111111 in DECODE SHALL give illegal_op=1 and next state 0.
REQ-039 Asserting reset during MEMWR while waiting SHALL drop mem_write to 0 within the same cycle and set state=0.
REQ-040 With HAS_ADDI=0, op 001000 SHALL give illegal_op=1; with the default, ADDI SHALL give states 0,1,9,7,0 with reg_dst=0 in state 7.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: sequences fetch, decode, memory, ALU, branch and jump
// steps and drives the datapath selects and write strobes combinationally from the current state.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter bit HAS_ADDI   = 1'b1,
    parameter bit HAS_BNE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic                  alu_src_a,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state,
    output logic                  illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       addi_ok_s;
    logic       bne_ok_s;
    logic       funct_ok_s;
    logic [3:0] funct_alu_s;
    logic       mem_req_s, mem_write_s, iord_s, ir_write_s, pc_en_s;
    logic       alu_src_a_s, reg_dst_s, mem_to_reg_s, reg_write_s, illegal_s;
    logic [1:0] alu_src_b_s, pc_src_s;
    logic [3:0] alu_ctrl_s;

    assign addi_ok_s = HAS_ADDI && (op == OP_ADDI);
    assign bne_ok_s  = HAS_BNE && (op == OP_BNE);

    // State register; reset pulls the FSM back to FETCH asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // R-type function field to ALU operation.
    always_comb begin
        funct_ok_s  = 1'b1;
        funct_alu_s = ALU_AND;
        case (funct)
            6'b100000: funct_alu_s = ALU_ADD;
            6'b100010: funct_alu_s = ALU_SUB;
            6'b100100: funct_alu_s = ALU_AND;
            6'b100101: funct_alu_s = ALU_OR;
            6'b100111: funct_alu_s = ALU_NOR;
            6'b101010: funct_alu_s = ALU_SLT;
            default:   funct_ok_s  = 1'b0;
        endcase
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_nxt_s  = state_r;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_en_s      = 1'b0;
        alu_src_a_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu_ctrl_s   = 4'b0000;
        case (state_r)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = 2'b01;
                alu_ctrl_s  = ALU_ADD;
                if (mem_ready) begin
                    ir_write_s  = 1'b1;
                    pc_en_s     = 1'b1;
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                alu_ctrl_s  = ALU_ADD;
                if ((op == OP_LW) || (op == OP_SW)) begin
                    state_nxt_s = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_nxt_s = S_RTEXEC;
                end else if ((op == OP_BEQ) || bne_ok_s) begin
                    state_nxt_s = S_BRANCH;
                end else if (addi_ok_s) begin
                    state_nxt_s = S_ADDIEX;
                end else if (op == OP_J) begin
                    state_nxt_s = S_JUMP;
                end else begin
                    illegal_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_ctrl_s  = ALU_ADD;
                if (op == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_nxt_s = S_MEMWR;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_nxt_s  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_RTEXEC: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = funct_alu_s;
                if (funct_ok_s) begin
                    state_nxt_s = S_ALUWB;
                end else begin
                    illegal_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end
            end
            S_ALUWB: begin
                // ADDI shares this writeback but targets rt, not rd.
                reg_write_s = 1'b1;
                reg_dst_s   = ~addi_ok_s;
                state_nxt_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = ALU_SUB;
                pc_src_s    = 2'b01;
                pc_en_s     = bne_ok_s ? ~zero : zero;
                state_nxt_s = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_ctrl_s  = ALU_ADD;
                state_nxt_s = S_ALUWB;
            end
            S_JUMP: begin
                pc_src_s    = 2'b10;
                pc_en_s     = 1'b1;
                state_nxt_s = S_FETCH;
            end
            default: begin
                state_nxt_s = S_FETCH;
            end
        endcase
    end

    // Write strobes are masked while reset is held so FETCH cannot commit anything.
    assign ir_write    = ir_write_s  & ~reset;
    assign pc_en       = pc_en_s     & ~reset;
    assign reg_write   = reg_write_s & ~reset;
    assign mem_write   = mem_write_s & ~reset;
    assign mem_req     = mem_req_s;
    assign iord        = iord_s;
    assign alu_src_a   = alu_src_a_s;
    assign reg_dst     = reg_dst_s;
    assign mem_to_reg  = mem_to_reg_s;
    assign alu_src_b   = alu_src_b_s;
    assign pc_src      = pc_src_s;
    assign alu_control = ALU_CTRL_W'(alu_ctrl_s);
    assign state       = state_r;
    assign illegal_op  = illegal_s;

endmodule
